// File: rtl/izh_neuron_array.sv
// Time-multiplexed Izhikevich neuron array.
// One shared fixed-point datapath steps every neuron once per start.
module izh_neuron_array #(
  parameter int N_NEURONS = 16,
  parameter int W = 32,
  parameter int FRAC = 16,
  parameter int H_SHIFT = 0,
  parameter logic signed [W-1:0] V_INIT = W'(-(64'sd65 <<< FRAC)),
  parameter logic signed [W-1:0] U_INIT = W'(-(64'sd13 <<< FRAC)),
  parameter int IDX_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [N_NEURONS*W-1:0] i_flat,
  input  logic [W-1:0]           a,
  input  logic [W-1:0]           b,
  input  logic [W-1:0]           c,
  input  logic [W-1:0]           d,
  input  logic [W-1:0]           vpeak,
  output logic                   busy,
  output logic                   done,
  output logic [N_NEURONS-1:0]   spike_vec,
  input  logic [IDX_W-1:0]       rd_idx,
  output logic [W-1:0]           v_rd,
  output logic [W-1:0]           u_rd
);

  typedef logic signed [W-1:0]   word_t;
  typedef logic signed [2*W-1:0] wide_t;
  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_M1, S_M2, S_WB, S_FIN
  } state_t;

  localparam word_t MAXV = {1'b0, {(W-1){1'b1}}};
  localparam word_t MINV = {1'b1, {(W-1){1'b0}}};
  localparam word_t K004 = W'(((64'sd4 <<< FRAC) + 64'sd50) / 64'sd100);
  localparam word_t K5   = W'(64'sd5 <<< FRAC);
  localparam word_t K140 = W'(64'sd140 <<< FRAC);
  localparam int    LAST = N_NEURONS - 1;

  function automatic word_t sat(input wide_t x);
    if (x > wide_t'(MAXV)) return MAXV;
    if (x < wide_t'(MINV)) return MINV;
    return x[W-1:0];
  endfunction

  function automatic word_t mul(input word_t x, input word_t y);
    wide_t p;
    p = wide_t'(x) * wide_t'(y);
    return sat(p >>> FRAC);
  endfunction

  function automatic word_t add(input word_t x, input word_t y);
    return sat(wide_t'(x) + wide_t'(y));
  endfunction

  function automatic word_t sub(input word_t x, input word_t y);
    return sat(wide_t'(x) - wide_t'(y));
  endfunction

  state_t state_q, state_d;
  logic [IDX_W-1:0] k_q, k_d;
  word_t v_q [N_NEURONS];
  word_t v_d [N_NEURONS];
  word_t u_q [N_NEURONS];
  word_t u_d [N_NEURONS];
  word_t i_q [N_NEURONS];
  word_t i_d [N_NEURONS];
  word_t a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d, vp_q, vp_d;
  word_t vr_q, vr_d, ur_q, ur_d;
  word_t vv_q, vv_d, bv_q, bv_d, fv_q, fv_d;
  word_t t4_q, t4_d, du_q, du_d;
  logic [N_NEURONS-1:0] shd_q, shd_d, spk_q, spk_d;
  logic busy_q, busy_d, done_q, done_d;

  word_t dv, vn, un;
  logic  spk;

  // Writeback arithmetic for the neuron currently in the pipeline
  always_comb begin
    dv  = add(add(add(t4_q, fv_q), K140), i_q[k_q]);
    dv  = add(sub(add(add(t4_q, fv_q), K140), ur_q), i_q[k_q]);
    vn  = add(vr_q, dv >>> H_SHIFT);
    un  = add(ur_q, du_q >>> H_SHIFT);
    spk = (vn >= vp_q);
  end

  // Sequencer and next-state for storage and pipeline registers
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    v_d = v_q;
    u_d = u_q;
    i_d = i_q;
    a_d = a_q; b_d = b_q; c_d = c_q; d_d = d_q; vp_d = vp_q;
    vr_d = vr_q; ur_d = ur_q;
    vv_d = vv_q; bv_d = bv_q; fv_d = fv_q;
    t4_d = t4_q; du_d = du_q;
    shd_d = shd_q;
    spk_d = spk_q;
    busy_d = busy_q;
    done_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          for (int k = 0; k < N_NEURONS; k++)
            i_d[k] = i_flat[k*W +: W];
          a_d = a; b_d = b; c_d = c; d_d = d; vp_d = vpeak;
          busy_d = 1'b1;
          k_d = '0;
          shd_d = '0;
          state_d = S_RD;
        end
      end
      S_RD: begin
        vr_d = v_q[k_q];
        ur_d = u_q[k_q];
        state_d = S_M1;
      end
      S_M1: begin
        vv_d = mul(vr_q, vr_q);
        bv_d = mul(b_q, vr_q);
        fv_d = mul(K5, vr_q);
        state_d = S_M2;
      end
      S_M2: begin
        t4_d = mul(K004, vv_q);
        du_d = mul(a_q, sub(bv_q, ur_q));
        state_d = S_WB;
      end
      S_WB: begin
        v_d[k_q] = spk ? c_q : vn;
        u_d[k_q] = spk ? add(un, d_q) : un;
        shd_d[k_q] = spk;
        if (int'(k_q) == LAST) begin
          spk_d = shd_d;
          done_d = 1'b1;
          state_d = S_FIN;
        end else begin
          k_d = IDX_W'(k_q + 1'b1);
          state_d = S_RD;
        end
      end
      S_FIN: begin
        busy_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q <= '0;
      for (int k = 0; k < N_NEURONS; k++) begin
        v_q[k] <= V_INIT;
        u_q[k] <= U_INIT;
        i_q[k] <= '0;
      end
      a_q <= '0; b_q <= '0; c_q <= '0; d_q <= '0; vp_q <= '0;
      vr_q <= '0; ur_q <= '0;
      vv_q <= '0; bv_q <= '0; fv_q <= '0;
      t4_q <= '0; du_q <= '0;
      shd_q <= '0;
      spk_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      v_q <= v_d;
      u_q <= u_d;
      i_q <= i_d;
      a_q <= a_d; b_q <= b_d; c_q <= c_d; d_q <= d_d; vp_q <= vp_d;
      vr_q <= vr_d; ur_q <= ur_d;
      vv_q <= vv_d; bv_q <= bv_d; fv_q <= fv_d;
      t4_q <= t4_d; du_q <= du_d;
      shd_q <= shd_d;
      spk_q <= spk_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign spike_vec = spk_q;
  assign v_rd = (int'(rd_idx) < N_NEURONS) ? v_q[rd_idx] : '0;
  assign u_rd = (int'(rd_idx) < N_NEURONS) ? u_q[rd_idx] : '0;

endmodule

// File: tb/tb_izh_neuron_array.sv
// Directed bench for izh_neuron_array.
// Hand constants plus a 64-bit reference model of the neuron update.
module tb_izh_neuron_array;

  localparam int N = 16;
  localparam int W = 32;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst, start;
  logic [N*W-1:0] i_flat;
  logic [W-1:0] a, b, c, d, vpeak;
  logic busy, done;
  logic [N-1:0] spike_vec;
  logic [IW-1:0] rd_idx;
  logic [W-1:0] v_rd, u_rd;

  izh_neuron_array dut (
    .clk(clk), .rst(rst), .start(start), .i_flat(i_flat),
    .a(a), .b(b), .c(c), .d(d), .vpeak(vpeak),
    .busy(busy), .done(done), .spike_vec(spike_vec),
    .rd_idx(rd_idx), .v_rd(v_rd), .u_rd(u_rd)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  longint mv [N];
  longint mu [N];
  longint cur_i [N];
  logic [N-1:0] mspk;
  longint ca, cb, cc, cd, cvp;

  function automatic longint clamp(input longint x);
    if (x > 64'sd2147483647) return 64'sd2147483647;
    if (x < -64'sd2147483648) return -64'sd2147483648;
    return x;
  endfunction

  function automatic longint mm(input longint x, input longint y);
    return clamp((x * y) >>> 16);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      mv[k] = -65 * 65536;
      mu[k] = -13 * 65536;
    end
  endtask

  task automatic model_step();
    longint v, u, dv, vn, du, un;
    for (int k = 0; k < N; k++) begin
      v = mv[k];
      u = mu[k];
      dv = clamp(mm(2621, mm(v, v)) + mm(327680, v));
      dv = clamp(dv + 140 * 65536);
      dv = clamp(dv - u);
      dv = clamp(dv + cur_i[k]);
      vn = clamp(v + dv);
      du = mm(ca, clamp(mm(cb, v) - u));
      un = clamp(u + du);
      mspk[k] = (vn >= cvp);
      if (mspk[k]) begin
        mv[k] = cc;
        mu[k] = clamp(un + cd);
      end else begin
        mv[k] = vn;
        mu[k] = un;
      end
    end
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) i_flat[k*W +: W] = cur_i[k][31:0];
    a = ca[31:0]; b = cb[31:0]; c = cc[31:0];
    d = cd[31:0]; vpeak = cvp[31:0];
  endtask

  task automatic chk_model(input string tag);
    logic [31:0] ev, eu;
    for (int k = 0; k < N; k++) begin
      rd_idx = IW'(k);
      #1;
      ev = mv[k][31:0];
      eu = mu[k][31:0];
      chk($sformatf("%s_v%0d", tag, k), v_rd, ev);
      chk($sformatf("%s_u%0d", tag, k), u_rd, eu);
    end
  endtask

  task automatic chk_const(input string tag, input logic [31:0] ev,
                           input logic [31:0] eu);
    for (int k = 0; k < N; k++) begin
      rd_idx = IW'(k);
      #1;
      chk($sformatf("%s_v%0d", tag, k), v_rd, ev);
      chk($sformatf("%s_u%0d", tag, k), u_rd, eu);
    end
  endtask

  // Pulse start, then watch for done; glitch adds stray start pulses.
  task automatic run_step(input bit glitch, output int lat, output int nd);
    @(negedge clk);
    drive();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    nd = 0;
    for (int t = 1; t <= 4*N + 12; t++) begin
      if (glitch && t == 10) start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (t == 1) chk("busy_after_accept", 32'(busy), 32'd1);
      if (done) begin
        nd++;
        if (lat < 0) lat = t + 1;
        if (glitch) start = 1'b1;
      end
    end
    #1 start = 1'b0;
    chk("busy_after_step", 32'(busy), 32'd0);
  endtask

  int lat, nd, steps;
  bit found;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    rd_idx = '0;
    i_flat = '0;
    ca = 1311; cb = 13107; cc = -65 * 65536;
    cd = 2 * 65536; cvp = 30 * 65536;
    for (int k = 0; k < N; k++) cur_i[k] = 0;
    drive();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_spk", 32'(spike_vec), 32'd0);
    chk_const("rst", 32'hFFBF0000, 32'hFFF30000);

    model_step();
    run_step(1'b0, lat, nd);
    chk("s1_latency", 32'(lat), 32'(4*N + 1));
    chk("s1_ndone", 32'(nd), 32'd1);
    chk("s1_spk", 32'(spike_vec), 32'd0);
    chk_const("s1", 32'hFFBBF8BD, 32'hFFF30000);

    cur_i[3] = 10 * 65536;
    found = 1'b0;
    steps = 0;
    while (!found && steps < 100) begin
      model_step();
      run_step(1'b0, lat, nd);
      steps++;
      chk($sformatf("n3_spk_step%0d", steps), 32'(spike_vec), 32'(mspk));
      if (mspk != '0) found = 1'b1;
    end
    chk("n3_found", 32'(found), 32'd1);
    chk("n3_spk_vec", 32'(spike_vec), 32'h0008);
    rd_idx = 4'd3;
    #1 chk("n3_v_is_c", v_rd, 32'hFFBF0000);
    chk_model("n3");

    model_step();
    run_step(1'b1, lat, nd);
    chk("gl_latency", 32'(lat), 32'(4*N + 1));
    chk("gl_ndone", 32'(nd), 32'd1);
    chk("gl_spk", 32'(spike_vec), 32'(mspk));
    chk_model("gl");

    @(negedge clk) rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    for (int k = 0; k < N; k++) cur_i[k] = 0;
    cur_i[0] = 64'h7FFF0000;
    cvp = 64'sh7FFFFFFF;

    model_step();
    run_step(1'b0, lat, nd);
    chk("sat1_spk", 32'(spike_vec), 32'd0);
    rd_idx = 4'd0;
    #1 chk("sat1_v0", v_rd, 32'h7FBAF8BD);
    chk_model("sat1");

    model_step();
    run_step(1'b0, lat, nd);
    chk("sat2_spk", 32'(spike_vec), 32'h0001);
    rd_idx = 4'd0;
    #1 chk("sat2_v0_is_c", v_rd, 32'hFFBF0000);
    chk("sat2_u0_sign", 32'(u_rd[31]), 32'd0);
    chk_model("sat2");

    @(negedge clk);
    drive();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2*N - 1) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_spk", 32'(spike_vec), 32'd0);
    chk_const("ab", 32'hFFBF0000, 32'hFFF30000);
    nd = 0;
    for (int t = 0; t < 4*N + 10; t++) begin
      @(posedge clk);
      #1 if (done) nd++;
    end
    chk("ab_ndone", 32'(nd), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
